bht_update_ctrl: RTL and testbench
==================================

// Module: bht_update_ctrl
//
// PURPOSE
//   Sequences all writes into the branch history tracker (BHT) table.
//   - Buffers resolved-branch outcomes from EX in a small in-order FIFO.
//   - Issues at most one table write per cycle, and only when the BHT write port is not held.
//   - Runs a table-wide clear sweep on pipeline flush.
//   - Sits between the EX branch-resolve logic and the BHT write/update port.
//
// PARAMETERS
//   INDEX_WIDTH  10  BHT index width; table has 2**INDEX_WIDTH entries
//   FIFO_DEPTH    4  pending-update FIFO entries; power of 2, >= 2
//
// PORTS
//   clk_i        in   1                        clock; all state updates on rising edge
//   rst_i        in   1                        synchronous, active-high reset
//   flush_i      in   1                        start (or restart) table clear sweep
//   hold_i       in   1                        BHT write port unavailable this cycle
//   upd_valid_i  in   1                        resolved branch update offered
//   upd_index_i  in   INDEX_WIDTH              BHT index of resolved branch
//   upd_taken_i  in   1                        branch outcome, 1 = taken
//   upd_ready_o  out  1                        update accepted this cycle if valid
//   wr_en_o      out  1                        BHT write strobe
//   wr_index_o   out  INDEX_WIDTH              BHT entry to write
//   wr_taken_o   out  1                        outcome applied to the entry's 2-bit counter
//   wr_clear_o   out  1                        force entry to reset state (00); only with wr_en_o
//   busy_o       out  1                        clear sweep in progress
//   count_o      out  $clog2(FIFO_DEPTH)+1     FIFO occupancy
//   dropped_o    out  1                        registered pulse: an update was lost
//
// BEHAVIOUR
//   FSM: RUN, CLEAR. Reset -> RUN.
//
//   Reset state
//   - FIFO empty; sweep counter 0.
//   - All registered outputs 0: wr_*, busy_o, count_o, dropped_o.
//   - upd_ready_o = 1.
//
//   Accept rule
//   - upd_ready_o = (state == RUN) && (count < FIFO_DEPTH).
//   - Based on registered count only, so a full FIFO refuses even in a cycle it pops.
//   - Handshake = upd_valid_i && upd_ready_o && !flush_i.
//   - Accepted {index, taken} is pushed at the clock edge.
//
//   RUN write issue
//   - wr_en_o = !empty && !hold_i; wr_index_o / wr_taken_o = FIFO head; wr_clear_o = 0.
//   - The FIFO pops in the same cycle as wr_en_o.
//   - Minimum latency: accepted at edge t -> wr_en_o during cycle t+1.
//   - Writes leave in strict acceptance order; no coalescing of equal indices.
//   - Simultaneous push and pop: count unchanged.
//   - hold_i = 1 freezes the head; pushes continue until full.
//
//   Dropped updates
//   - dropped_o = 1 in cycle t+1 when, in cycle t, upd_valid_i = 1 and either upd_ready_o = 0 or flush_i = 1.
//   - Dropped updates are never written.
//
//   RUN -> CLEAR on flush_i
//   - All FIFO contents are discarded (count_o -> 0) and the sweep counter is set to 0.
//
//   CLEAR sweep
//   - busy_o = 1.
//   - wr_en_o = !hold_i, wr_clear_o = 1, wr_index_o = sweep counter, wr_taken_o = 0.
//   - The counter advances by 1 on each issued write; hold_i pauses it.
//   - After the write at index 2**INDEX_WIDTH - 1, the FSM returns to RUN on the next edge.
//   - The sweep takes exactly 2**INDEX_WIDTH unheld cycles.
//   - flush_i during CLEAR restarts the sweep at index 0, with no write skipped or repeated out of order.
//   - Counter wrap never occurs: the terminal index ends the sweep.
//
//   Reset priority
//   - rst_i mid-sweep or mid-drain abandons all work; the next cycle shows reset values.
//   - rst_i has priority over flush_i and the handshake.
//
//   Write-port output rule
//   - wr_* depend combinationally only on internal state and hold_i; there is no path from upd_* or flush_i.
//
// TESTING (INDEX_WIDTH=3, FIFO_DEPTH=4)
//   1. hold_i=0; push (1,T),(2,N),(3,T) on consecutive cycles
//      -> wr_en_o in the three following cycles with index 1,2,3, taken 1,0,1; count_o peaks at 1.
//   2. hold_i=1; offer 5 updates back-to-back
//      -> first 4 accepted; upd_ready_o=0 at count 4; dropped_o pulses once.
//      Release hold -> 4 ordered writes, then count_o=0.
//   3. 2 updates pending, flush_i for 1 cycle
//      -> count_o=0; busy_o=1 for 8 cycles; wr_clear_o with indices 0..7; then upd_ready_o=1, busy_o=0.
//   4. flush_i again when sweep reaches index 5
//      -> next write is index 0; busy_o stays high 8 more cycles; no write of indices 6,7 before restart.
//   5. hold_i=1 for 3 cycles during CLEAR at index 2
//      -> wr_en_o=0, index stays 2, then resumes; total busy_o = 11 cycles.
//   6. rst_i at sweep index 4 with upd_valid_i=1
//      -> next cycle busy_o=0, wr_en_o=0, count_o=0, upd_ready_o=1, dropped_o=0.

Source files
------------

// File: rtl/bht_update_ctrl.sv
// Purpose: sequence all BHT table writes: in-order resolved-branch FIFO plus flush clear sweep.
// Latency: update accepted at edge t is written during cycle t+1 at the earliest; sweep takes 2**INDEX_WIDTH unheld cycles.
// Backpressure: hold_i stalls writes and pauses the sweep; upd_ready_o drops when the FIFO is full or a sweep is running.
module bht_update_ctrl #(
   parameter int INDEX_WIDTH = 10,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          flush_i,
   input  logic                          hold_i,
   input  logic                          upd_valid_i,
   input  logic [INDEX_WIDTH-1:0]        upd_index_i,
   input  logic                          upd_taken_i,
   output logic                          upd_ready_o,
   output logic                          wr_en_o,
   output logic [INDEX_WIDTH-1:0]        wr_index_o,
   output logic                          wr_taken_o,
   output logic                          wr_clear_o,
   output logic                          busy_o,
   output logic [$clog2(FIFO_DEPTH):0]   count_o,
   output logic                          dropped_o
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [0:0] {S_RUN, S_CLEAR} state_t;

   typedef struct packed {
      logic [INDEX_WIDTH-1:0] index;
      logic                   taken;
   } upd_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   upd_t                   r_mem [FIFO_DEPTH];
   logic [PW-1:0]          r_rd_ptr;
   logic [PW-1:0]          r_wr_ptr;
   logic [CW-1:0]          r_count;
   logic [INDEX_WIDTH-1:0] r_sweep;
   logic                   r_dropped;

   logic                   w_empty;
   logic                   w_ready;
   logic                   w_push;
   logic                   w_pop;
   logic                   w_sweep_last;
   upd_t                   w_head;
   logic                   w_wr_en;
   logic [INDEX_WIDTH-1:0] w_wr_index;
   logic                   w_wr_taken;
   logic                   w_wr_clear;
   logic                   w_busy;

   // Acceptance looks only at registered occupancy, so a full FIFO refuses even while it pops.
   assign w_empty      = (r_count == '0);
   assign w_ready      = (r_state == S_RUN) && (r_count < CW'(FIFO_DEPTH));
   assign w_push       = upd_valid_i && w_ready && !flush_i;
   assign w_pop        = (r_state == S_RUN) && w_wr_en;
   assign w_sweep_last = (r_sweep == '1);
   assign w_head       = r_mem[r_rd_ptr];

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= S_RUN;
      else       r_state <= w_state_nxt;
   end

   // Next state and write-port outputs; write port sees only state and hold_i, never upd_* or flush_i.
   always_comb begin
      w_state_nxt = r_state;
      w_wr_en     = 1'b0;
      w_wr_index  = '0;
      w_wr_taken  = 1'b0;
      w_wr_clear  = 1'b0;
      w_busy      = 1'b0;
      case (r_state)
         S_RUN: begin
            w_wr_en = !w_empty && !hold_i;
            if (!w_empty) begin
               w_wr_index = w_head.index;
               w_wr_taken = w_head.taken;
            end
            if (flush_i) w_state_nxt = S_CLEAR;
         end
         S_CLEAR: begin
            w_busy     = 1'b1;
            w_wr_en    = !hold_i;
            w_wr_clear = 1'b1;
            w_wr_index = r_sweep;
            // A flush on the terminal index restarts rather than exits.
            if (!flush_i && !hold_i && w_sweep_last) w_state_nxt = S_RUN;
         end
         default: w_state_nxt = S_RUN;
      endcase
   end

   // Sweep counter: restart on flush, advance on each issued clear, stop at the terminal index.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_sweep <= '0;
      end else if (flush_i) begin
         r_sweep <= '0;
      end else if ((r_state == S_CLEAR) && !hold_i) begin
         r_sweep <= w_sweep_last ? '0 : r_sweep + INDEX_WIDTH'(1);
      end
   end

   // FIFO storage; contents need no reset since occupancy gates every read.
   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wr_ptr] <= '{index: upd_index_i, taken: upd_taken_i};
   end

   // FIFO pointers and occupancy; a flush from RUN discards everything pending.
   always_ff @(posedge clk_i) begin
      if (rst_i || ((r_state == S_RUN) && flush_i)) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Dropped pulse: an offered update that was refused or collided with a flush.
   always_ff @(posedge clk_i) begin
      if (rst_i) r_dropped <= 1'b0;
      else       r_dropped <= upd_valid_i && (!w_ready || flush_i);
   end

   assign upd_ready_o = w_ready;
   assign wr_en_o     = w_wr_en;
   assign wr_index_o  = w_wr_index;
   assign wr_taken_o  = w_wr_taken;
   assign wr_clear_o  = w_wr_clear;
   assign busy_o      = w_busy;
   assign count_o     = r_count;
   assign dropped_o   = r_dropped;

endmodule

// File: tb/tb_bht_update_ctrl.sv
// Purpose: directed bench for bht_update_ctrl with INDEX_WIDTH=3, FIFO_DEPTH=4.
// Latency: inputs driven 1 time unit after each rising edge, outputs sampled on the falling edge.
// Backpressure: hold_i patterns exercise FIFO fill, stalled drain and paused sweep.
module tb_bht_update_ctrl;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic       flush_i = 1'b0;
   logic       hold_i = 1'b0;
   logic       upd_valid_i = 1'b0;
   logic [2:0] upd_index_i = 3'd0;
   logic       upd_taken_i = 1'b0;
   logic       upd_ready_o;
   logic       wr_en_o;
   logic [2:0] wr_index_o;
   logic       wr_taken_o;
   logic       wr_clear_o;
   logic       busy_o;
   logic [2:0] count_o;
   logic       dropped_o;

   int checks = 0;
   int failures = 0;

   // Observation vector {wr_en, index, taken, clear, busy, count, ready, dropped};
   // index/taken are only meaningful with wr_en so they are masked otherwise.
   logic [11:0] obs;
   logic [11:0] obs_raw;
   assign obs     = {wr_en_o, wr_index_o & {3{wr_en_o}}, wr_taken_o & wr_en_o, wr_clear_o,
                     busy_o, count_o, upd_ready_o, dropped_o};
   assign obs_raw = {wr_en_o, wr_index_o, wr_taken_o, wr_clear_o,
                     busy_o, count_o, upd_ready_o, dropped_o};

   bht_update_ctrl #(.INDEX_WIDTH(3), .FIFO_DEPTH(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .hold_i(hold_i),
      .upd_valid_i(upd_valid_i), .upd_index_i(upd_index_i), .upd_taken_i(upd_taken_i),
      .upd_ready_o(upd_ready_o), .wr_en_o(wr_en_o), .wr_index_o(wr_index_o),
      .wr_taken_o(wr_taken_o), .wr_clear_o(wr_clear_o), .busy_o(busy_o),
      .count_o(count_o), .dropped_o(dropped_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic drive_cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      logic [11:0] exp;
      rst_i = 1'b1;
      drive_cycle();
      drive_cycle();
      rst_i = 1'b0;
      @(negedge clk_i);
      exp = {1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0};
      checks++;
      if (obs_raw !== exp) begin
         failures++;
         $display("FAIL reset_state obs=%h exp=%h", obs_raw, exp);
      end
   endtask

   task automatic test_back_to_back();
      logic [11:0] exp;
      logic [2:0]  idx [4];
      logic        tk  [4];
      idx[0] = 3'd1; idx[1] = 3'd2; idx[2] = 3'd3; idx[3] = 3'd0;
      tk[0]  = 1'b1; tk[1]  = 1'b0; tk[2]  = 1'b1; tk[3]  = 1'b0;
      hold_i = 1'b0;
      for (int c = 0; c < 5; c++) begin
         drive_cycle();
         upd_valid_i = (c < 3);
         upd_index_i = idx[c % 4];
         upd_taken_i = tk[c % 4];
         @(negedge clk_i);
         if (c == 0)      exp = {1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0};
         else if (c < 4)  exp = {1'b1, idx[c-1], tk[c-1], 1'b0, 1'b0, 3'd1, 1'b1, 1'b0};
         else             exp = {1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0};
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL back_to_back cyc=%0d obs=%h exp=%h", c, obs, exp);
         end
      end
      upd_valid_i = 1'b0;
   endtask

   task automatic test_full_hold();
      logic [11:0] exp;
      logic [2:0]  idx [5];
      logic        tk  [5];
      idx[0] = 3'd4; idx[1] = 3'd5; idx[2] = 3'd6; idx[3] = 3'd7; idx[4] = 3'd0;
      tk[0]  = 1'b1; tk[1]  = 1'b0; tk[2]  = 1'b0; tk[3]  = 1'b1; tk[4]  = 1'b1;
      for (int k = 0; k < 5; k++) begin
         drive_cycle();
         hold_i      = 1'b1;
         upd_valid_i = 1'b1;
         upd_index_i = idx[k];
         upd_taken_i = tk[k];
         @(negedge clk_i);
         exp = {1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'(k), (k < 4) ? 1'b1 : 1'b0, 1'b0};
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL full_fill k=%0d obs=%h exp=%h", k, obs, exp);
         end
      end
      // Refused fifth offer shows up as a single dropped pulse.
      for (int k = 0; k < 2; k++) begin
         drive_cycle();
         upd_valid_i = 1'b0;
         @(negedge clk_i);
         exp = {1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, (k == 0) ? 1'b1 : 1'b0};
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL full_dropped k=%0d obs=%h exp=%h", k, obs, exp);
         end
      end
      for (int j = 0; j < 5; j++) begin
         drive_cycle();
         hold_i = 1'b0;
         @(negedge clk_i);
         if (j < 4) exp = {1'b1, idx[j], tk[j], 1'b0, 1'b0, 3'(4 - j), (j > 0) ? 1'b1 : 1'b0, 1'b0};
         else       exp = {1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0};
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL full_drain j=%0d obs=%h exp=%h", j, obs, exp);
         end
      end
   endtask

   task automatic test_flush_sweep();
      logic [11:0] exp;
      for (int c = 0; c < 3; c++) begin
         drive_cycle();
         hold_i      = 1'b1;
         upd_valid_i = (c < 2);
         upd_index_i = 3'(c + 1);
         upd_taken_i = 1'b1;
         flush_i     = (c == 2);
         @(negedge clk_i);
         exp = {1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'(c), 1'b1, 1'b0};
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL flush_pre c=%0d obs=%h exp=%h", c, obs, exp);
         end
      end
      for (int i = 0; i < 9; i++) begin
         drive_cycle();
         flush_i = 1'b0;
         hold_i  = 1'b0;
         @(negedge clk_i);
         if (i < 8) exp = {1'b1, 3'(i), 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0};
         else       exp = {1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0};
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL flush_sweep i=%0d obs=%h exp=%h", i, obs, exp);
         end
      end
   endtask

   task automatic test_flush_restart();
      logic [11:0] exp;
      drive_cycle();
      flush_i = 1'b1;
      @(negedge clk_i);
      for (int i = 0; i < 15; i++) begin
         drive_cycle();
         flush_i = (i == 5);
         @(negedge clk_i);
         if (i < 6)       exp = {1'b1, 3'(i), 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0};
         else if (i < 14) exp = {1'b1, 3'(i - 6), 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0};
         else             exp = {1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0};
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL flush_restart i=%0d obs=%h exp=%h", i, obs, exp);
         end
      end
      flush_i = 1'b0;
   endtask

   task automatic test_sweep_hold();
      logic [11:0] exp;
      int busy_cycles = 0;
      bit done = 0;
      drive_cycle();
      flush_i = 1'b1;
      @(negedge clk_i);
      for (int c = 0; c < 40 && !done; c++) begin
         drive_cycle();
         flush_i = 1'b0;
         hold_i  = (c >= 2 && c < 5);
         @(negedge clk_i);
         if (!busy_o) begin
            done = 1;
         end else begin
            busy_cycles++;
            if (c < 2)      exp = {1'b1, 3'(c), 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0};
            else if (c < 5) exp = {1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0};
            else            exp = {1'b1, 3'(c - 3), 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0};
            checks++;
            if (obs !== exp) begin
               failures++;
               $display("FAIL sweep_hold c=%0d obs=%h exp=%h", c, obs, exp);
            end
            if (c >= 2 && c < 5) begin
               checks++;
               if (wr_index_o !== 3'd2) begin
                  failures++;
                  $display("FAIL sweep_hold_index c=%0d got=%0d exp=2", c, wr_index_o);
               end
            end
         end
      end
      hold_i = 1'b0;
      checks++;
      if (!done || busy_cycles != 11) begin
         failures++;
         $display("FAIL sweep_hold_busy_len got=%0d exp=11 ended=%0b", busy_cycles, done);
      end
   endtask

   task automatic test_reset_mid_sweep();
      logic [11:0] exp;
      drive_cycle();
      flush_i = 1'b1;
      @(negedge clk_i);
      for (int i = 0; i < 6; i++) begin
         drive_cycle();
         flush_i     = 1'b0;
         rst_i       = (i == 4);
         upd_valid_i = (i == 4);
         upd_index_i = 3'd3;
         @(negedge clk_i);
         if (i < 5) exp = {1'b1, 3'(i), 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0};
         else       exp = {1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0};
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL reset_mid_sweep i=%0d obs=%h exp=%h", i, obs, exp);
         end
      end
      rst_i       = 1'b0;
      upd_valid_i = 1'b0;
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_full_hold();
      test_flush_sweep();
      test_flush_restart();
      test_sweep_hold();
      test_reset_mid_sweep();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
